uart_rx_fifo: RTL and testbench

- Standalone UART receiver for the SoC peripheral path: 16x oversampled, majority-voted 8-bit frames, optional parity, 8-entry receive FIFO with a valid/ready output.
- Pairs with the existing UART transmit path.
- Sits between the board-level rx pin and SoC-side logic.
- Also serves as the host-side monitor in system benches.

---
 rtl/uart_rx_fifo.sv | 159 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 16x oversampled UART receiver with 2-of-3 majority voting, optional parity,
// and a show-ahead receive FIFO with a valid/ready pop interface.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic                        rx_i,
  input  logic [DIV_W-1:0]            baud_div_i,
  input  logic                        parity_en_i,
  input  logic                        parity_odd_i,
  output logic [7:0]                  rx_data_o,
  output logic                        rx_valid_o,
  input  logic                        rx_ready_i,
  output logic                        frame_err_o,
  output logic                        parity_err_o,
  output logic                        overrun_o,
  input  logic                        err_clr_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        rx_busy_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]       sync_reg;
  logic             rx_s;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [3:0]       sub_reg;
  logic [2:0]       bit_reg;
  logic [1:0]       smp_reg;
  logic             tick, mid, bit_end, maj;
  logic             shift_en, par_sample, stop_decide;
  logic [7:0]       shift_reg;
  logic             perr_reg;
  logic             push_reg;
  logic [9:0]       push_word_reg;

  // Line synchronizer, preset to the idle level so reset never fakes a start bit
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) sync_reg <= 2'b11;
    else           sync_reg <= {sync_reg[0], rx_i};
  end
  assign rx_s = sync_reg[1];

  assign tick    = (state_reg != ST_IDLE) && (div_cnt_reg == baud_div_i);
  assign mid     = tick && (sub_reg == 4'd9);
  assign bit_end = tick && (sub_reg == 4'd15);
  assign maj     = (smp_reg[0] & smp_reg[1]) | (smp_reg[0] & rx_s) | (smp_reg[1] & rx_s);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      div_cnt_reg <= '0;
      sub_reg     <= '0;
      bit_reg     <= '0;
    end else begin
      if (state_reg == ST_IDLE || tick) div_cnt_reg <= '0;
      else                              div_cnt_reg <= div_cnt_reg + DIV_W'(1);
      if (state_reg == ST_IDLE) sub_reg <= '0;
      else if (tick)            sub_reg <= sub_reg + 4'd1;
      if (state_reg != ST_DATA) bit_reg <= '0;
      else if (bit_end)         bit_reg <= bit_reg + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_reg <= ST_IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (!rx_s) state_next = ST_START;
      ST_START: begin
        if (mid && maj)   state_next = ST_IDLE;
        else if (bit_end) state_next = ST_DATA;
      end
      ST_DATA:   if (bit_end && bit_reg == 3'd7) state_next = parity_en_i ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_next = ST_STOP;
      // Leave the stop bit at its decision point so a back-to-back start edge is caught early
      ST_STOP:   if (mid) state_next = maj ? ST_IDLE : ST_BREAK;
      ST_BREAK:  if (rx_s) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_busy_o   = (state_reg != ST_IDLE);
    shift_en    = (state_reg == ST_DATA) && mid;
    par_sample  = (state_reg == ST_PARITY) && mid;
    stop_decide = (state_reg == ST_STOP) && mid;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      smp_reg       <= '0;
      shift_reg     <= '0;
      perr_reg      <= 1'b0;
      push_reg      <= 1'b0;
      push_word_reg <= '0;
    end else begin
      if (tick && sub_reg == 4'd7) smp_reg[0] <= rx_s;
      if (tick && sub_reg == 4'd8) smp_reg[1] <= rx_s;
      if (shift_en) shift_reg <= {maj, shift_reg[7:1]};
      if (state_reg == ST_IDLE) perr_reg <= 1'b0;
      else if (par_sample)      perr_reg <= (^shift_reg ^ maj) != parity_odd_i;
      push_reg <= stop_decide;
      if (stop_decide) push_word_reg <= {perr_reg, ~maj, shift_reg};
    end
  end

  logic [9:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             full, do_push, do_pop, drop;
  logic [9:0]       head;

  assign rx_valid_o = (count_reg != '0);
  assign full       = (count_reg == CNT_W'(FIFO_DEPTH));
  assign do_pop     = rx_valid_o & rx_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
  assign do_push    = push_reg & (~full | do_pop);
  assign drop       = push_reg & full & ~do_pop;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_reg] <= push_word_reg;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      overrun_o  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
      if (drop)           overrun_o <= 1'b1;
      else if (err_clr_i) overrun_o <= 1'b0;
    end
  end

  // Head is gated so unwritten storage never shows up on the outputs
  assign head         = rx_valid_o ? mem[rd_ptr_reg] : '0;
  assign rx_data_o    = head[7:0];
  assign frame_err_o  = head[8];
  assign parity_err_o = head[9];
  assign fifo_count_o = count_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo: serial frames are built from byte/parity/stop
// choices and the expected FIFO contents come from a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int FIFO_DEPTH = 8;
  localparam int DIV_W      = 16;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        rx_i = 1'b1;
  logic [15:0] baud_div_i = 16'd3;
  logic        parity_en_i = 1'b0;
  logic        parity_odd_i = 1'b0;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        frame_err_o;
  logic        parity_err_o;
  logic        overrun_o;
  logic        err_clr_i = 1'b0;
  logic [3:0]  fifo_count_o;
  logic        rx_busy_o;

  logic man_rdy = 1'b0;
  logic rand_rdy = 1'b0;
  logic rand_mode = 1'b0;
  assign rx_ready_i = rand_mode ? rand_rdy : man_rdy;

  uart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .rx_i(rx_i), .baud_div_i(baud_div_i),
    .parity_en_i(parity_en_i), .parity_odd_i(parity_odd_i),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .frame_err_o(frame_err_o), .parity_err_o(parity_err_o), .overrun_o(overrun_o),
    .err_clr_i(err_clr_i), .fifo_count_o(fifo_count_o), .rx_busy_o(rx_busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: entries {parity_err, frame_err, data} in arrival order
  logic [9:0] exp_q[$];
  logic       model_ovr = 1'b0;
  logic [9:0] mon_e;

  function automatic void model_push(input logic [9:0] e);
    if (exp_q.size() >= FIFO_DEPTH) model_ovr = 1'b1;
    else exp_q.push_back(e);
  endfunction

  always @(negedge clk_i) begin
    if (reset_ni && rx_valid_o && rx_ready_i) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(rx_valid_o), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_data", 32'(rx_data_o), 32'(mon_e[7:0]));
        check("pop_frame_err", 32'(frame_err_o), 32'(mon_e[8]));
        check("pop_parity_err", 32'(parity_err_o), 32'(mon_e[9]));
        $display("pop  data=%02h fe=%0b pe=%0b", rx_data_o, frame_err_o, parity_err_o);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      rand_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic int bitc();
    return 16 * (int'(baud_div_i) + 1);
  endfunction

  task automatic send_bit(input logic b);
    rx_i = b;
    step(bitc());
  endtask

  // Leaves rx_i at the last driven level; callers return the line to idle
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop, input int extra_low);
    logic perr;
    parity_en_i = pen;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    perr = pen && ((^d ^ pbit) != parity_odd_i);
    model_push({perr, ~stop, d});
    send_bit(stop);
    for (int i = 0; i < extra_low; i++) send_bit(1'b0);
    $display("send data=%02h par_en=%0b odd=%0b pbit=%0b stop=%0b div=%0d",
             d, pen, parity_odd_i, pbit, stop, baud_div_i);
  endtask

  task automatic drain();
    int n;
    man_rdy = 1'b1;
    n = 0;
    while (fifo_count_o != 0 && n < 64) begin
      step(1);
      n++;
    end
    man_rdy = 1'b0;
    check("drain_count", 32'(fifo_count_o), 32'd0);
    step(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(rx_valid_o), 32'd0);
    check({tag, "_data"}, 32'(rx_data_o), 32'd0);
    check({tag, "_ferr"}, 32'(frame_err_o), 32'd0);
    check({tag, "_perr"}, 32'(parity_err_o), 32'd0);
    check({tag, "_ovr"}, 32'(overrun_o), 32'd0);
    check({tag, "_count"}, 32'(fifo_count_o), 32'd0);
    check({tag, "_busy"}, 32'(rx_busy_o), 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] d;
    logic pen, pbit, stop;
    int extra;

    #2;
    check_all_zero("reset");
    step(2);
    reset_ni = 1'b1;
    step(4);

    // 8N1 0xA5 at 64 clocks per bit
    baud_div_i = 16'd3;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 0);
    rx_i = 1'b1;
    step(bitc());
    check("t1_valid", 32'(rx_valid_o), 32'd1);
    check("t1_data", 32'(rx_data_o), 32'hA5);
    check("t1_ferr", 32'(frame_err_o), 32'd0);
    check("t1_perr", 32'(parity_err_o), 32'd0);
    check("t1_count", 32'(fifo_count_o), 32'd1);
    man_rdy = 1'b1;
    step(1);
    man_rdy = 1'b0;
    check("t1_valid_after_pop", 32'(rx_valid_o), 32'd0);

    // False start: 4-clock low glitch at the fastest rate
    baud_div_i = 16'd0;
    step(2);
    rx_i = 1'b0;
    step(4);
    check("t2_busy_start", 32'(rx_busy_o), 32'd1);
    rx_i = 1'b1;
    n = 0;
    while (rx_busy_o && n < 40) begin
      step(1);
      n++;
    end
    check("t2_busy_cleared", 32'(rx_busy_o), 32'd0);
    step(20);
    check("t2_count", 32'(fifo_count_o), 32'd0);
    check("t2_valid", 32'(rx_valid_o), 32'd0);

    // Framing error followed by a long break, then a clean frame
    baud_div_i = 16'd3;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 3);
    check("t3_busy_in_break", 32'(rx_busy_o), 32'd1);
    check("t3_count_in_break", 32'(fifo_count_o), 32'd1);
    rx_i = 1'b1;
    step(bitc());
    check("t3_busy_after_break", 32'(rx_busy_o), 32'd0);
    check("t3_data", 32'(rx_data_o), 32'h3C);
    check("t3_ferr", 32'(frame_err_o), 32'd1);
    check("t3_perr", 32'(parity_err_o), 32'd0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 0);
    rx_i = 1'b1;
    step(bitc());
    check("t3_count2", 32'(fifo_count_o), 32'd2);
    drain();

    // Even parity: wrong then right parity bit for 0x07
    parity_odd_i = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 0);
    rx_i = 1'b1;
    step(bitc());
    check("t4_perr_bad", 32'(parity_err_o), 32'd1);
    drain();
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 0);
    rx_i = 1'b1;
    step(bitc());
    check("t4_perr_good", 32'(parity_err_o), 32'd0);
    check("t4_data", 32'(rx_data_o), 32'h07);
    drain();

    // Overrun: nine bytes into an eight-entry FIFO with no consumer
    for (int i = 1; i <= 9; i++) begin
      d = 8'(i);
      send_frame(d, 1'b0, 1'b0, 1'b1, 0);
      rx_i = 1'b1;
      step(bitc());
    end
    check("t5_count", 32'(fifo_count_o), 32'(exp_q.size()));
    check("t5_overrun", 32'(overrun_o), 32'(model_ovr));
    drain();
    check("t5_model_empty", 32'(exp_q.size()), 32'd0);
    check("t5_overrun_sticky", 32'(overrun_o), 32'd1);
    err_clr_i = 1'b1;
    step(1);
    err_clr_i = 1'b0;
    model_ovr = 1'b0;
    check("t5_overrun_clr", 32'(overrun_o), 32'(model_ovr));

    // Reset in the middle of data bit 4 with one byte already queued
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 0);
    rx_i = 1'b1;
    step(bitc());
    d = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx_i = d[4];
    step(bitc() / 2);
    reset_ni = 1'b0;
    exp_q.delete();
    model_ovr = 1'b0;
    #1;
    check_all_zero("t6_reset");
    step(3);
    rx_i = 1'b1;
    reset_ni = 1'b1;
    step(bitc());
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 0);
    rx_i = 1'b1;
    step(bitc());
    check("t6_count", 32'(fifo_count_o), 32'd1);
    check("t6_data", 32'(rx_data_o), 32'hC3);
    check("t6_ferr", 32'(frame_err_o), 32'd0);
    check("t6_perr", 32'(parity_err_o), 32'd0);
    drain();

    // Randomized frames with a randomly stalling consumer
    rand_mode = 1'b1;
    for (int it = 0; it < 24; it++) begin
      baud_div_i = 16'($urandom_range(0, 3));
      parity_odd_i = 1'($urandom_range(0, 1));
      d = 8'($urandom_range(0, 255));
      pen = 1'($urandom_range(0, 1));
      pbit = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 5) != 0);
      extra = stop ? 0 : int'($urandom_range(1, 2));
      send_frame(d, pen, pbit, stop, extra);
      rx_i = 1'b1;
      step(bitc() * int'($urandom_range(1, 3)));
    end
    rand_mode = 1'b0;
    drain();
    check("rand_model_empty", 32'(exp_q.size()), 32'd0);
    check("rand_overrun", 32'(overrun_o), 32'(model_ovr));
    check("rand_busy", 32'(rx_busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
